// File: rtl/switch_cfg_pkg.sv
// Shared constants, FSM state type and select-legality helper for the
// switch-matrix configuration loader.
package switch_cfg_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Source-edge codes carried in select bits [2:0]
    localparam logic [2:0] SEL_NONE   = 3'd0;
    localparam logic [2:0] SEL_TOP    = 3'd1;
    localparam logic [2:0] SEL_RIGHT  = 3'd2;
    localparam logic [2:0] SEL_BOTTOM = 3'd3;
    localparam logic [2:0] SEL_LEFT   = 3'd4;

    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CSUM   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    // A select is legal when its edge code exists and its pin index is
    // below the width of the source edge. "None" accepts any index.
    function automatic logic sel_legal(input logic [2:0] code,
                                       input int unsigned idx,
                                       input int unsigned ntop,
                                       input int unsigned nside);
        logic ok;
        ok = 1'b0;
        case (code)
            SEL_NONE:             ok = 1'b1;
            SEL_TOP, SEL_BOTTOM:  ok = (idx < ntop);
            SEL_RIGHT, SEL_LEFT:  ok = (idx < nside);
            default:              ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/switch_cfg_loader_deser.sv
// MSB-first bit deserialiser. `word` is the W-bit value including the bit
// being offered this cycle, so a consumer can act on the completed word on
// the same edge that accepts its last bit (`word_done`).
module cfg_bit_deser #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         shift,
    input  logic         bit_in,
    output logic [W-1:0] word,
    output logic         word_done
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [W-2:0] shreg;
    logic [CW-1:0] cnt;

    assign word      = {shreg, bit_in};
    assign word_done = shift && (cnt == CW'(W - 1));

    // History shifts on every accepted bit; the bit counter wraps after W-1
    // and is re-aligned to a word boundary by `clear`.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else begin
            if (shift) begin
                shreg <= word[W-2:0];
            end
            if (clear) begin
                cnt <= '0;
            end else if (shift) begin
                cnt <= (cnt == CW'(W - 1)) ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_cfg_loader.sv
// Serial configuration loader for one switch-matrix tile. Frames are
// SYNC_BYTE, N select entries, then an 8-bit additive checksum. Entries land
// in shadow registers; the active cfg_* words are only updated by a fully
// checked frame, so the matrix never sees a partial route.
//
// Handshake: a bit transfers on a rising edge where in_valid && in_ready.
// in_ready is high in HUNT/LOAD/CSUM and low during CHECK/COMMIT; in_valid
// may drop at any time and the loader simply waits.
module switch_cfg_loader
    import switch_cfg_pkg::*;
#(
    parameter int NTOP  = 5,
    parameter int NSIDE = 4,
    parameter int SELW  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_bit,
    output logic                  in_ready,
    output logic [NTOP*SELW-1:0]  cfg_top,
    output logic [NTOP*SELW-1:0]  cfg_bottom,
    output logic [NSIDE*SELW-1:0] cfg_left,
    output logic [NSIDE*SELW-1:0] cfg_right,
    output logic                  cfg_loaded,
    output logic                  cfg_err,
    output logic                  busy,
    output logic [2:0]            fsm_state
);

    localparam int N   = 2 * NTOP + 2 * NSIDE;
    localparam int ECW = $clog2(N);

    state_t          state;
    logic [ECW-1:0]  entry_cnt;
    logic [7:0]      sum;
    logic            bad;
    logic [SELW-1:0] shadow [N];

    logic            accept;
    logic            byte_shift;
    logic [7:0]      byte_word;
    logic            byte_done;
    logic            ent_shift;
    logic [SELW-1:0] ent_word;
    logic            ent_done;
    logic            sync_hit;
    logic            ent_legal;

    assign accept     = in_valid && in_ready;
    assign byte_shift = accept && ((state == ST_HUNT) || (state == ST_CSUM));
    assign ent_shift  = accept && (state == ST_LOAD);
    assign sync_hit   = accept && (state == ST_HUNT) && (byte_word == SYNC_BYTE);
    assign ent_legal  = sel_legal(ent_word[2:0], 32'(ent_word[SELW-1:3]),
                                  NTOP, NSIDE);
    assign fsm_state  = state;

    // The byte deserialiser doubles as the sync window in HUNT and the
    // checksum collector in CSUM; sync detection re-aligns its counter.
    cfg_bit_deser #(.W(8)) u_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (sync_hit),
        .shift     (byte_shift),
        .bit_in    (in_bit),
        .word      (byte_word),
        .word_done (byte_done)
    );

    cfg_bit_deser #(.W(SELW)) u_entry (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (sync_hit),
        .shift     (ent_shift),
        .bit_in    (in_bit),
        .word      (ent_word),
        .word_done (ent_done)
    );

    // Frame FSM with registered handshake/status outputs, shadow capture
    // and the commit of shadow to the active select words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_HUNT;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            cfg_err    <= 1'b0;
            cfg_loaded <= 1'b0;
            entry_cnt  <= '0;
            sum        <= '0;
            bad        <= 1'b0;
            cfg_top    <= '0;
            cfg_bottom <= '0;
            cfg_left   <= '0;
            cfg_right  <= '0;
            for (int i = 0; i < N; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            cfg_err <= 1'b0;
            case (state)
                ST_HUNT: begin
                    if (sync_hit) begin
                        state     <= ST_LOAD;
                        busy      <= 1'b1;
                        entry_cnt <= '0;
                        sum       <= '0;
                        bad       <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (ent_done) begin
                        shadow[entry_cnt] <= ent_word;
                        sum <= sum + 8'(ent_word);
                        bad <= bad | ~ent_legal;
                        if (entry_cnt == ECW'(N - 1)) begin
                            state <= ST_CSUM;
                        end else begin
                            entry_cnt <= entry_cnt + 1'b1;
                        end
                    end
                end
                ST_CSUM: begin
                    // The verdict is registered into cfg_err so the pulse
                    // covers exactly the CHECK cycle.
                    if (byte_done) begin
                        state    <= ST_CHECK;
                        in_ready <= 1'b0;
                        cfg_err  <= (byte_word != sum) || bad;
                    end
                end
                ST_CHECK: begin
                    if (cfg_err) begin
                        state    <= ST_HUNT;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end else begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    for (int i = 0; i < NTOP; i++) begin
                        cfg_top[i*SELW +: SELW]    <= shadow[i];
                        cfg_bottom[i*SELW +: SELW] <= shadow[NTOP + i];
                    end
                    for (int i = 0; i < NSIDE; i++) begin
                        cfg_left[i*SELW +: SELW]   <= shadow[2*NTOP + i];
                        cfg_right[i*SELW +: SELW]  <= shadow[2*NTOP + NSIDE + i];
                    end
                    cfg_loaded <= 1'b1;
                    busy       <= 1'b0;
                    in_ready   <= 1'b1;
                    state      <= ST_HUNT;
                end
                default: begin
                    state    <= ST_HUNT;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_cfg_loader.sv
// Directed bench for switch_cfg_loader: frames are built from an entry
// table, the expected active configuration is pushed to a queue when a frame
// is driven and compared once the loader has checked/committed it.
module tb_switch_cfg_loader;

    localparam int NTOP  = 5;
    localparam int NSIDE = 4;
    localparam int SELW  = 6;
    localparam int N     = 2 * NTOP + 2 * NSIDE;
    localparam int EXP_W = 1 + 2 * NTOP * SELW + 2 * NSIDE * SELW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic in_ready;
    logic [NTOP*SELW-1:0]  cfg_top;
    logic [NTOP*SELW-1:0]  cfg_bottom;
    logic [NSIDE*SELW-1:0] cfg_left;
    logic [NSIDE*SELW-1:0] cfg_right;
    logic cfg_loaded;
    logic cfg_err;
    logic busy;
    logic [2:0] fsm_state;

    int tests = 0;
    int fails = 0;

    logic [EXP_W-1:0] exp_q[$];
    logic [SELW-1:0]  ent [N];

    logic                  mod_loaded;
    logic [NTOP*SELW-1:0]  mod_top;
    logic [NTOP*SELW-1:0]  mod_bottom;
    logic [NSIDE*SELW-1:0] mod_left;
    logic [NSIDE*SELW-1:0] mod_right;

    // clock
    always #5 clk = ~clk;

    switch_cfg_loader #(.NTOP(NTOP), .NSIDE(NSIDE), .SELW(SELW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .in_ready   (in_ready),
        .cfg_top    (cfg_top),
        .cfg_bottom (cfg_bottom),
        .cfg_left   (cfg_left),
        .cfg_right  (cfg_right),
        .cfg_loaded (cfg_loaded),
        .cfg_err    (cfg_err),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic tb_legal(input logic [5:0] e);
        logic [2:0] code;
        int idx;
        code = e[2:0];
        idx  = int'(e[5:3]);
        case (code)
            3'd0:       return 1'b1;
            3'd1, 3'd3: return idx < NTOP;
            3'd2, 3'd4: return idx < NSIDE;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [EXP_W-1:0] obs_vec();
        return {cfg_loaded, cfg_top, cfg_bottom, cfg_left, cfg_right};
    endfunction

    function automatic logic [EXP_W-1:0] model_vec();
        return {mod_loaded, mod_top, mod_bottom, mod_left, mod_right};
    endfunction

    // driver: optional idle gap, then one bit held for one rising edge
    task automatic send_bit(input logic b, input int gap_max);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (g) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic clear_ent();
        for (int i = 0; i < N; i++) ent[i] = '0;
    endtask

    task automatic random_ent();
        logic [2:0] code;
        logic [2:0] idx;
        for (int i = 0; i < N; i++) begin
            code = 3'($urandom_range(0, 4));
            if (code == 3'd0)                        idx = 3'($urandom_range(0, 7));
            else if (code == 3'd1 || code == 3'd3)  idx = 3'($urandom_range(0, NTOP - 1));
            else                                     idx = 3'($urandom_range(0, NSIDE - 1));
            ent[i] = {idx, code};
        end
    endtask

    task automatic send_sync(input int gap_max);
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 0; i < 8; i++) send_bit(1'b0, gap_max);
        for (int b = 7; b >= 0; b--) begin
            send_bit(s[b], gap_max);
            if (b == 1) check("busy_before_sync", busy, 1'b0);
        end
        check("busy_on_sync", busy, 1'b1);
    endtask

    // one full frame from ent[], optionally with a forced checksum
    task automatic send_frame(input bit force_csum, input logic [7:0] csum_in, input int gap_max);
        logic [7:0] sum;
        logic [7:0] csum;
        bit good;
        logic [EXP_W-1:0] prev_vec;
        logic [EXP_W-1:0] exp_vec;
        sum  = 8'h00;
        good = 1'b1;
        for (int i = 0; i < N; i++) begin
            sum  = sum + {2'b00, ent[i]};
            good = good & tb_legal(ent[i]);
        end
        csum = force_csum ? csum_in : sum;
        if (csum != sum) good = 1'b0;
        prev_vec = model_vec();
        if (good) begin
            mod_loaded = 1'b1;
            for (int i = 0; i < NTOP; i++) begin
                mod_top[i*SELW +: SELW]    = ent[i];
                mod_bottom[i*SELW +: SELW] = ent[NTOP + i];
            end
            for (int i = 0; i < NSIDE; i++) begin
                mod_left[i*SELW +: SELW]  = ent[2*NTOP + i];
                mod_right[i*SELW +: SELW] = ent[2*NTOP + NSIDE + i];
            end
        end
        exp_q.push_back(model_vec());

        send_sync(gap_max);
        for (int i = 0; i < N; i++)
            for (int b = SELW - 1; b >= 0; b--) send_bit(ent[i][b], gap_max);
        for (int b = 7; b >= 0; b--) send_bit(csum[b], gap_max);

        // CHECK cycle
        check("err_in_check", cfg_err, !good);
        check("ready_in_check", in_ready, 1'b0);
        check("busy_in_check", busy, 1'b1);
        @(posedge clk);
        #1;
        check("err_one_cycle", cfg_err, 1'b0);
        if (good) begin
            check("hold_until_commit", obs_vec(), prev_vec);
            check("busy_in_commit", busy, 1'b1);
            @(posedge clk);
            #1;
        end
        check("busy_after_frame", busy, 1'b0);
        check("ready_after_frame", in_ready, 1'b1);
        exp_vec = exp_q.pop_front();
        check("scoreboard_cfg", obs_vec(), exp_vec);
    endtask

    initial begin
        logic [7:0] win;
        logic jb;
        logic [7:0] s;

        mod_loaded = 1'b0;
        mod_top    = '0;
        mod_bottom = '0;
        mod_left   = '0;
        mod_right  = '0;

        // reset then idle
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_top", cfg_top, '0);
        check("reset_bottom", cfg_bottom, '0);
        check("reset_left", cfg_left, '0);
        check("reset_right", cfg_right, '0);
        check("reset_loaded", cfg_loaded, 1'b0);
        check("reset_err", cfg_err, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_ready", in_ready, 1'b1);

        // bottom[4] sourced from right[1], checksum 0x0A
        clear_ent();
        ent[NTOP + 4] = 6'b001010;
        send_frame(1'b0, 8'h00, 0);
        check("bottom4_value", cfg_bottom[29:24], 6'b001010);
        check("loaded_set", cfg_loaded, 1'b1);

        // same frame with a wrong checksum: rejected, outputs held
        send_frame(1'b1, 8'h0B, 0);

        // illegal top pin index with a correct checksum 0x29: rejected
        clear_ent();
        ent[0] = 6'b101001;
        send_frame(1'b0, 8'h00, 0);
        check("bottom4_kept", cfg_bottom[29:24], 6'b001010);

        // random junk (never forming the sync byte), then a gapped frame
        for (int i = 0; i < 8; i++) send_bit(1'b0, 0);
        win = 8'h00;
        for (int i = 0; i < 40; i++) begin
            jb = 1'($urandom_range(0, 1));
            if ({win[6:0], jb} == 8'hA5) jb = ~jb;
            win = {win[6:0], jb};
            send_bit(jb, 1);
            check("busy_during_junk", busy, 1'b0);
        end
        random_ent();
        send_frame(1'b0, 8'h00, 3);

        // another random frame, back to back
        random_ent();
        send_frame(1'b0, 8'h00, 1);

        // reset pulsed after 40 frame bits (sync + 32 entry bits)
        random_ent();
        send_sync(0);
        for (int i = 0; i < 32; i++) send_bit(ent[i / SELW][SELW - 1 - (i % SELW)], 0);
        check("busy_mid_frame", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        mod_loaded = 1'b0;
        mod_top    = '0;
        mod_bottom = '0;
        mod_left   = '0;
        mod_right  = '0;
        check("async_reset_cfg", obs_vec(), model_vec());
        check("async_reset_busy", busy, 1'b0);
        check("async_reset_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // complete frame after reset loads normally
        random_ent();
        send_frame(1'b0, 8'h00, 2);

        // a hand-built frame exercising every edge code
        clear_ent();
        s = 8'h00;
        ent[1]  = 6'b100001;
        ent[6]  = 6'b011010;
        ent[12] = 6'b010011;
        ent[17] = 6'b000100;
        ent[3]  = 6'b111000;
        send_frame(1'b0, s, 0);
        check("top1_value", cfg_top[11:6], 6'b100001);
        check("right3_value", cfg_right[23:18], 6'b000100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
